dct_vecrot_ctrl: RTL and testbench
==================================

Name: dct_vecrot_ctrl

Overview:
Frame sequencer for the DCT vector-rotation stage.
- Accepts a frame start with the transform size.
- Generates paired read addresses k and N-k for the FFT result buffer.
- Drives sink_valid of the rotation-coefficient generator.
- Emits a delayed valid/first/last strobe aligned with the coefficient outputs.
- Sits between the FFT output buffer and the vector-rotation multiplier.

Parameters:
- wAddr, 11, read-address width (max N = 2048).
- DLY_ALIGN, 2, cycles from coeff_valid to coefficient outputs (coefficient generator latency); range 1..7.
- GAP_MIN, 1, minimum idle cycles with coeff_valid low between frames; the generator clears its address only while sink_valid is low; range 1..15.

Ports:
- clk  in  1  clock
- rst_sync  in  1  synchronous reset, active-high
- start  in  1  frame start pulse; accepted only in IDLE
- fftpts_in  in  12  transform size N sampled with start: 32, 64, 128, 256, 512, 1024 or 2048
- fftpts_out  out  12  latched N; drives the coefficient generator fftpts_in for the whole frame
- busy  out  1  high from accepted start until GAP done
- coeff_valid  out  1  sink_valid to the coefficient generator; high for exactly N consecutive cycles
- rd_en  out  1  equal to coeff_valid
- rd_addr_a  out  wAddr  k = 0..N-1
- rd_addr_b  out  wAddr  mirror index: 0 when k=0, else N-k
- out_valid  out  1  coeff_valid delayed DLY_ALIGN cycles
- out_first  out  1  out_valid and k=0, delayed
- out_last  out  1  out_valid and k=N-1, delayed
- frame_done  out  1  one-cycle pulse, same cycle as out_last
- cfg_err  out  1  sticky; set by invalid N or by start while busy; cleared only by reset

Behaviour:
- Reset values: all outputs 0, fftpts_out = 12'd2048, state IDLE, delay line cleared. Reset mid-frame aborts immediately; no frame_done is produced.
- States: IDLE, RUN, FLUSH, GAP.
- IDLE: on start with valid N:
  - latch fftpts_out;
  - k <= 0;
  - go to RUN next cycle; busy rises that cycle.
- IDLE, start with invalid N: set cfg_err, stay IDLE, outputs unchanged.
- RUN:
  - coeff_valid = rd_en = 1;
  - rd_addr_a = k, rd_addr_b = (k==0) ? 0 : N-k, computed modulo 2^wAddr with no overflow for N = 2048;
  - k increments every cycle with no stall;
  - at k = N-1, go to FLUSH.
- FLUSH: coeff_valid = 0; wait until the delay line is empty (DLY_ALIGN cycles after the last RUN cycle), then go to GAP.
- GAP: hold GAP_MIN cycles, counted from the first cycle coeff_valid is low, overlapping FLUSH; then go to IDLE and drop busy.
- Start while busy: ignored; sets cfg_err; does not disturb the frame in progress.
- Start in IDLE during the same cycle frame_done fires: not possible, since busy is still high, so the start is treated as while-busy.
- Delay line: shift register of {valid, first, last}, DLY_ALIGN deep.
  - out_valid is the registered output of the last stage.
  - out_first occurs exactly once per frame; out_last occurs exactly once per frame.
  - frame_done = out_last.
- fftpts_out is constant from start acceptance until busy falls.

Optional Feature:
DCT_VECROT_CTRL_FRMCNT_EN
- Defined: adds output frame_cnt [15:0]. It increments on each frame_done, wraps 65535 -> 0, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with N=32 -> coeff_valid high 32 cycles; rd_addr_a 0..31; rd_addr_b 0,31,30..1; out_valid 32 cycles beginning DLY_ALIGN cycles after coeff_valid; one frame_done; busy low DLY_ALIGN+1 cycles after the last valid when GAP_MIN ≤ DLY_ALIGN+1.
- N=2048 -> rd_addr_b at k=1 is 2047; at k=1024 it is 1024; 2048 valid cycles; no address overflow.
- Start with fftpts_in=100 -> cfg_err=1, busy stays 0, coeff_valid stays 0.
- Start pulse at cycle 5 of a running N=64 frame -> frame completes unchanged (64 valids), cfg_err=1.
- Back-to-back starts with N=128 then N=1024, the second issued the cycle busy falls -> coeff_valid low ≥ GAP_MIN cycles between frames; fftpts_out switches only at the second acceptance.
- rst_sync asserted at k=10 of an N=256 frame -> next cycle all outputs 0, state IDLE, no frame_done; with FRMCNT_EN, frame_cnt=0.

Source files
------------

// File: rtl/dct_vecrot_ctrl_if.sv
// -----------------------------------------------------------------------------
// dct_vecrot_ctrl_if
// Bundles the frame-control and read/strobe signals of the DCT vector-rotation
// sequencer so the sequencer and its environment share one port.
//
// Optional feature macro: DCT_VECROT_CTRL_FRMCNT_EN (adds frame_cnt[15:0]).
//
// Signals (direction as seen by the sequencer, modport "slave"):
//   start        in   frame start pulse
//   fftpts_in    in   transform size N sampled with start
//   fftpts_out   out  latched N for the coefficient generator
//   busy         out  frame in progress (start accepted .. gap done)
//   coeff_valid  out  sink_valid to the coefficient generator
//   rd_en        out  FFT buffer read enable (== coeff_valid)
//   rd_addr_a    out  read index k
//   rd_addr_b    out  mirror index (0 at k=0, else N-k)
//   out_valid    out  coeff_valid delayed to the coefficient outputs
//   out_first    out  delayed first-sample strobe
//   out_last     out  delayed last-sample strobe
//   frame_done   out  one-cycle end-of-frame pulse
//   cfg_err      out  sticky configuration/protocol error
//   frame_cnt    out  completed-frame counter (macro only)
// The "master" modport is the mirror image, used by whoever drives start.
// -----------------------------------------------------------------------------
interface dct_vecrot_ctrl_if #(
  parameter int wAddr = 11
);
  logic             start;
  logic [11:0]      fftpts_in;
  logic [11:0]      fftpts_out;
  logic             busy;
  logic             coeff_valid;
  logic             rd_en;
  logic [wAddr-1:0] rd_addr_a;
  logic [wAddr-1:0] rd_addr_b;
  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic             frame_done;
  logic             cfg_err;
`ifdef DCT_VECROT_CTRL_FRMCNT_EN
  logic [15:0]      frame_cnt;

  modport slave (
    input  start, fftpts_in,
    output fftpts_out, busy, coeff_valid, rd_en, rd_addr_a, rd_addr_b,
    output out_valid, out_first, out_last, frame_done, cfg_err, frame_cnt
  );

  modport master (
    output start, fftpts_in,
    input  fftpts_out, busy, coeff_valid, rd_en, rd_addr_a, rd_addr_b,
    input  out_valid, out_first, out_last, frame_done, cfg_err, frame_cnt
  );
`else
  modport slave (
    input  start, fftpts_in,
    output fftpts_out, busy, coeff_valid, rd_en, rd_addr_a, rd_addr_b,
    output out_valid, out_first, out_last, frame_done, cfg_err
  );

  modport master (
    output start, fftpts_in,
    input  fftpts_out, busy, coeff_valid, rd_en, rd_addr_a, rd_addr_b,
    input  out_valid, out_first, out_last, frame_done, cfg_err
  );
`endif
endinterface

// File: rtl/dct_vecrot_ctrl.sv
// -----------------------------------------------------------------------------
// dct_vecrot_ctrl
// Frame sequencer for the DCT vector-rotation stage. On an accepted start it
// latches N, streams paired FFT-buffer read addresses (k, N-k) for N cycles
// while driving the coefficient generator's sink_valid, then drains a
// DLY_ALIGN-deep strobe pipeline so out_valid/out_first/out_last line up with
// the generator's coefficient outputs, and finally enforces an idle gap so the
// generator can clear its address before the next frame.
//
// Optional feature macro: DCT_VECROT_CTRL_FRMCNT_EN adds bus.frame_cnt[15:0],
// a wrapping count of completed frames.
//
// Ports:
//   clk       clock
//   rst_sync  synchronous active-high reset (aborts any frame in progress)
//   bus       dct_vecrot_ctrl_if.slave (see the interface file for signals)
//
// Parameters:
//   wAddr      read-address width (N up to 2048 needs 11)
//   DLY_ALIGN  coefficient generator latency, 1..7
//   GAP_MIN    minimum idle cycles between frames, 1..15
// -----------------------------------------------------------------------------
module dct_vecrot_ctrl #(
  parameter int wAddr     = 11,
  parameter int DLY_ALIGN = 2,
  parameter int GAP_MIN   = 1
) (
  input  logic               clk,
  input  logic               rst_sync,
  dct_vecrot_ctrl_if.slave   bus
);

  localparam logic [4:0] DLY_L = 5'(DLY_ALIGN);
  localparam logic [4:0] GAP_L = 5'(GAP_MIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [wAddr-1:0] k_q;
  logic [11:0]      fftpts_q;
  logic [4:0]       idle_cnt_q;   // idle cycles since the last RUN cycle, saturating
  logic             cfg_err_q;

  logic             n_ok;
  logic             k_last;
  logic [11:0]      k_ext;
  logic [11:0]      mirror;
  logic             coeff_valid;
  logic             busy;
  logic [wAddr-1:0] addr_a;
  logic [wAddr-1:0] addr_b;
  logic [2:0]       dly_out;      // {valid, first, last} at the coefficient outputs

  // Only the power-of-two sizes the generator supports are accepted.
  always_comb begin
    case (bus.fftpts_in)
      12'd32, 12'd64, 12'd128, 12'd256, 12'd512, 12'd1024, 12'd2048: n_ok = 1'b1;
      default: n_ok = 1'b0;
    endcase
  end

  // Mirror index uses 12-bit arithmetic, then truncates: N=2048 never overflows.
  assign k_ext  = 12'(k_q);
  assign k_last = (k_ext == fftpts_q - 12'd1);
  assign mirror = fftpts_q - k_ext;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst_sync) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start && n_ok)        state_d = S_RUN;
      S_RUN:   if (k_last)                   state_d = S_FLUSH;
      // Last strobe leaves the delay line DLY_ALIGN cycles after the last RUN cycle.
      S_FLUSH: if (idle_cnt_q >= DLY_L)      state_d = S_GAP;
      // The gap count started with FLUSH, so a short GAP_MIN costs one GAP cycle only.
      S_GAP:   if (idle_cnt_q >= GAP_L)      state_d = S_IDLE;
      default:                               state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    coeff_valid = (state_q == S_RUN);
    busy        = (state_q != S_IDLE);
    addr_a      = '0;
    addr_b      = '0;
    if (coeff_valid) begin
      addr_a = k_q;
      addr_b = (k_q == '0) ? '0 : mirror[wAddr-1:0];
    end
  end

  // ---------------- frame datapath ----------------
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      k_q        <= '0;
      fftpts_q   <= 12'd2048;
      idle_cnt_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.start && n_ok) begin
        fftpts_q <= bus.fftpts_in;
        k_q      <= '0;
      end else if (state_q == S_RUN) begin
        k_q <= k_q + 1'b1;
      end

      // A start is an error if the size is bad or a frame is still in progress.
      if (bus.start && (busy || !n_ok))
        cfg_err_q <= 1'b1;

      case (state_q)
        S_RUN:          idle_cnt_q <= 5'd1;
        S_FLUSH, S_GAP: if (idle_cnt_q != 5'd31) idle_cnt_q <= idle_cnt_q + 5'd1;
        default:        idle_cnt_q <= '0;
      endcase
    end
  end

  // ---------------- strobe delay line ----------------
  genvar gi;
  generate
    for (gi = 0; gi < DLY_ALIGN; gi++) begin : g_dly
      logic [2:0] stage_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst_sync) stage_q <= '0;
          else          stage_q <= {coeff_valid, coeff_valid && (k_q == '0), coeff_valid && k_last};
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst_sync) stage_q <= '0;
          else          stage_q <= g_dly[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign dly_out = g_dly[DLY_ALIGN-1].stage_q;

`ifdef DCT_VECROT_CTRL_FRMCNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_sync)        frame_cnt_q <= '0;
    else if (dly_out[0]) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

  assign bus.fftpts_out  = fftpts_q;
  assign bus.busy        = busy;
  assign bus.coeff_valid = coeff_valid;
  assign bus.rd_en       = coeff_valid;
  assign bus.rd_addr_a   = addr_a;
  assign bus.rd_addr_b   = addr_b;
  assign bus.out_valid   = dly_out[2];
  assign bus.out_first   = dly_out[1];
  assign bus.out_last    = dly_out[0];
  assign bus.frame_done  = dly_out[0];
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_dct_vecrot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dct_vecrot_ctrl
// Scoreboard bench for dct_vecrot_ctrl. Every accepted start pushes the whole
// expected frame (one entry per read address and per delayed strobe, each with
// the cycle it must appear in) into queues; an independent negedge monitor pops
// and compares whenever the DUT presents coeff_valid or out_valid, and checks
// busy / cfg_err against windows computed from the frame rules.
// -----------------------------------------------------------------------------
module tb_dct_vecrot_ctrl;
  localparam int W = 11;
  localparam int D = 2;
  localparam int G = 1;
  localparam int TAIL = (G > D + 1) ? G : D + 1;
  localparam int NEVER = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst_sync = 1'b1;

  dct_vecrot_ctrl_if #(.wAddr(W)) bus ();

  dct_vecrot_ctrl #(.wAddr(W), .DLY_ALIGN(D), .GAP_MIN(G)) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {int stamp; int k; int n;} cv_t;
  typedef struct {int stamp; bit first; bit last;} ov_t;

  cv_t cq[$];
  ov_t oq[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  busy_rise = 0;
  int  busy_fall = 0;
  int  err_cyc = NEVER;
  int  exp_fc = 0;
  int  idle_run = 0;
  bit  seen_frame = 1'b0;
  int  last_n = 2048;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cyc %0d)", name, cyc);
  endtask

  // Drive start in the current cycle; the expected frame is queued from the rules.
  task automatic drive_start(input int n, input bit accept, output int at);
    at = cyc;
    bus.start     = 1'b1;
    bus.fftpts_in = 12'(n);
    if (accept) begin
      for (int k = 0; k < n; k++) begin
        cq.push_back('{at + 1 + k, k, n});
        oq.push_back('{at + 1 + k + D, (k == 0), (k == n - 1)});
      end
      busy_rise = at + 1;
      busy_fall = at + n + TAIL + 1;
      last_n    = n;
    end else if (err_cyc > at + 1) begin
      err_cyc = at + 1;
    end
    $display("start N=%0d %s at cyc %0d", n, accept ? "accepted" : "rejected", at);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic issue_start(input int n, input bit accept, output int at);
    @(posedge clk); #1;
    drive_start(n, accept, at);
  endtask

  task automatic check_reset_state();
    chk("rst_busy",        int'(bus.busy), 0);
    chk("rst_coeff_valid", int'(bus.coeff_valid), 0);
    chk("rst_rd_en",       int'(bus.rd_en), 0);
    chk("rst_rd_addr_a",   int'(bus.rd_addr_a), 0);
    chk("rst_rd_addr_b",   int'(bus.rd_addr_b), 0);
    chk("rst_out_valid",   int'(bus.out_valid), 0);
    chk("rst_out_first",   int'(bus.out_first), 0);
    chk("rst_out_last",    int'(bus.out_last), 0);
    chk("rst_frame_done",  int'(bus.frame_done), 0);
    chk("rst_cfg_err",     int'(bus.cfg_err), 0);
    chk("rst_fftpts_out",  int'(bus.fftpts_out), 2048);
`ifdef DCT_VECROT_CTRL_FRMCNT_EN
    chk("rst_frame_cnt",   int'(bus.frame_cnt), 0);
`endif
  endtask

  // Assert reset now; release after one edge and clear the reference model.
  task automatic do_reset();
    rst_sync = 1'b1;
    @(posedge clk); #1;
    cq.delete();
    oq.delete();
    busy_rise  = 0;
    busy_fall  = 0;
    err_cyc    = NEVER;
    exp_fc     = 0;
    idle_run   = 0;
    seen_frame = 1'b0;
    last_n     = 2048;
    rst_sync   = 1'b0;
    @(negedge clk);
    check_reset_state();
    $display("reset released at cyc %0d", cyc);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy || cq.size() > 0 || oq.size() > 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("wait_idle");
  endtask

  task automatic wait_cycle(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("wait_cycle");
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    cv_t c;
    ov_t o;
    bit  exp_cv;
    bit  exp_ov;
    forever begin
      @(negedge clk);
      if (!rst_sync) begin
        chk("busy",    int'(bus.busy),    int'(cyc >= busy_rise && cyc < busy_fall));
        chk("cfg_err", int'(bus.cfg_err), int'(cyc >= err_cyc));

        exp_cv = (cq.size() > 0) && (cq[0].stamp == cyc);
        chk("coeff_valid", int'(bus.coeff_valid), int'(exp_cv));
        chk("rd_en",       int'(bus.rd_en),       int'(exp_cv));
        if (exp_cv) begin
          c = cq.pop_front();
          chk("rd_addr_a",  int'(bus.rd_addr_a),  c.k);
          chk("rd_addr_b",  int'(bus.rd_addr_b),  (c.k == 0) ? 0 : c.n - c.k);
          chk("fftpts_out", int'(bus.fftpts_out), c.n);
        end

        if (bus.coeff_valid) begin
          if (seen_frame && idle_run > 0) chk("gap_min", int'(idle_run >= G), 1);
          idle_run   = 0;
          seen_frame = 1'b1;
        end else begin
          idle_run++;
        end

        exp_ov = (oq.size() > 0) && (oq[0].stamp == cyc);
        chk("out_valid", int'(bus.out_valid), int'(exp_ov));
`ifdef DCT_VECROT_CTRL_FRMCNT_EN
        chk("frame_cnt", int'(bus.frame_cnt), exp_fc);
`endif
        if (exp_ov) begin
          o = oq.pop_front();
          chk("out_first",  int'(bus.out_first),  int'(o.first));
          chk("out_last",   int'(bus.out_last),   int'(o.last));
          chk("frame_done", int'(bus.frame_done), int'(o.last));
          if (o.last) begin
            exp_fc = (exp_fc + 1) & 16'hffff;
            $display("frame_done at cyc %0d", cyc);
          end
        end else begin
          chk("out_first_idle",  int'(bus.out_first),  0);
          chk("out_last_idle",   int'(bus.out_last),   0);
          chk("frame_done_idle", int'(bus.frame_done), 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int at;
    int at2;
    int n;
    int guard;
    int sizes[4] = '{32, 64, 128, 256};

    bus.start     = 1'b0;
    bus.fftpts_in = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Basic N=32 frame and the largest size (mirror index without overflow).
    issue_start(32, 1'b1, at);
    wait_idle();
    issue_start(2048, 1'b1, at);
    wait_idle();

    // Unsupported size: error flagged, nothing starts, N stays latched.
    issue_start(100, 1'b0, at);
    repeat (4) @(negedge clk);
    chk("fftpts_hold", int'(bus.fftpts_out), last_n);

    // Start arriving at k=5 of a running N=64 frame.
    @(posedge clk); #1;
    do_reset();
    issue_start(64, 1'b1, at);
    wait_cycle(at + 1 + 5);
    drive_start(512, 1'b0, at2);
    wait_idle();

    // Back-to-back: second start issued in the first cycle busy is low.
    issue_start(128, 1'b1, at);
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) fail_now("busy_fall_wait");
    chk("fftpts_before_2nd", int'(bus.fftpts_out), 128);
    drive_start(1024, 1'b1, at2);
    @(negedge clk);
    chk("fftpts_after_2nd", int'(bus.fftpts_out), 1024);
    wait_idle();

    // Reset in the middle of an N=256 frame (while k=10 is on the bus).
    issue_start(256, 1'b1, at);
    wait_cycle(at + 1 + 10);
    do_reset();
    repeat (D + 4) @(negedge clk);

    // Randomised frames with occasional protocol-violating starts.
    for (int i = 0; i < 8; i++) begin
      n = sizes[$urandom_range(0, 3)];
      repeat ($urandom_range(0, 4)) @(posedge clk);
      issue_start(n, 1'b1, at);
      if ($urandom_range(0, 2) == 0) begin
        wait_cycle(at + 1 + int'($urandom_range(0, 31)));
        drive_start(sizes[$urandom_range(0, 3)], 1'b0, at2);
      end
      wait_idle();
      if ($urandom_range(0, 3) == 0) issue_start(int'($urandom_range(0, 4095)) | 1, 1'b0, at2);
    end

    repeat (D + 4) @(negedge clk);
    chk("coeff_queue_empty", cq.size(), 0);
    chk("out_queue_empty",   oq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cyc %0d)", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
